// File: rtl/neuron_pkg.sv
// Shared widths, FSM encoding and saturation limits for the neuron MAC datapath.
package neuron_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_ACC_W  = 2 * DEF_DATA_W - DEF_FRAC_W + 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MAC    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    // Three guard bits absorb the bias plus four full-scale products.
    function automatic int acc_width(input int data_w, input int frac_w);
        return 2 * data_w - frac_w + 3;
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed fixed-point multiply, rescaled by FRAC_W and sign-extended
// to the accumulator width.
module fxp_mul #(
    parameter int DATA_W = neuron_pkg::DEF_DATA_W,
    parameter int FRAC_W = neuron_pkg::DEF_FRAC_W,
    parameter int ACC_W  = neuron_pkg::DEF_ACC_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  p
);

    logic signed [2*DATA_W-1:0] full;

    assign full = a * b;
    // Arithmetic shift floors toward -infinity; the upper bits dropped by the cast
    // are pure sign copies.
    assign p = ACC_W'(full >>> FRAC_W);

endmodule

// File: rtl/neuron_mac_unit.sv
// One neuron evaluation per request: bias + sum(data_i * weight_i) in signed fixed
// point, one multiply per cycle, then saturation and optional ReLU.
module neuron_mac_unit #(
    parameter int DATA_W = neuron_pkg::DEF_DATA_W,
    parameter int FRAC_W = neuron_pkg::DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic [DATA_W-1:0] weight0,
    input  logic [DATA_W-1:0] weight1,
    input  logic [DATA_W-1:0] weight2,
    input  logic [DATA_W-1:0] weight3,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    import neuron_pkg::*;

    localparam int ACC_W = acc_width(DATA_W, FRAC_W);

    localparam logic [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]               state;
    logic [1:0]               idx;
    logic signed [ACC_W-1:0]  acc;
    logic                     relu_q;
    logic [DATA_W-1:0]        data_q   [4];
    logic [DATA_W-1:0]        weight_q [4];

    logic signed [ACC_W-1:0]  prod;
    logic [DATA_W-1:0]        sat_res;
    logic                     sat_ovf;
    logic [DATA_W-1:0]        fin_res;

    fxp_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .a (data_q[idx]),
        .b (weight_q[idx]),
        .p (prod)
    );

    // NOTE: every output of this block gets a value on every path before any
    // branch, so no latch can be inferred.
    always_comb begin
        sat_res = acc[DATA_W-1:0];
        sat_ovf = 1'b0;
        if (acc > ACC_MAX) begin
            sat_res = RES_MAX;
            sat_ovf = 1'b1;
        end else if (acc < ACC_MIN) begin
            sat_res = RES_MIN;
            sat_ovf = 1'b1;
        end
        fin_res = (relu_q && sat_res[DATA_W-1]) ? '0 : sat_res;
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            acc      <= '0;
            relu_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            // NOTE: the operand bank is four small flop words, so it is reset;
            // a RAM-backed store would be left out of the reset tree.
            for (int i = 0; i < 4; i++) begin
                data_q[i]   <= '0;
                weight_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_q[0]   <= data0;
                        data_q[1]   <= data1;
                        data_q[2]   <= data2;
                        data_q[3]   <= data3;
                        weight_q[0] <= weight0;
                        weight_q[1] <= weight1;
                        weight_q[2] <= weight2;
                        weight_q[3] <= weight3;
                        relu_q      <= relu_en;
                        // Bias already sits at product scale; only sign extension needed.
                        acc         <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
                        idx         <= 2'd0;
                        busy        <= 1'b1;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + prod;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    result   <= fin_res;
                    overflow <= sat_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Scoreboard bench for neuron_mac_unit: directed corner cases plus randomized
// requests checked against an integer-arithmetic reference model.
module tb_neuron_mac_unit;

    import neuron_pkg::*;

    typedef struct {
        logic [31:0] d [4];
        logic [31:0] w [4];
        logic [31:0] b;
        logic        relu;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0;
    logic [31:0] weight0 = '0, weight1 = '0, weight2 = '0, weight3 = '0;
    logic [31:0] bias = '0;
    logic        relu_en = 1'b0;
    logic        busy, done, overflow;
    logic [31:0] result;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb [$];
    int          busy_lo = 1, busy_hi = 0, next_free = 0;
    logic [31:0] held_res = '0;
    logic        held_ovf = 1'b0;
    op_t         last_op;

    neuron_mac_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .data3    (data3),
        .weight0  (weight0),
        .weight1  (weight1),
        .weight2  (weight2),
        .weight3  (weight3),
        .bias     (bias),
        .relu_en  (relu_en),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer arithmetic, floor-scaled products, then clamp.
    function automatic exp_t model(input op_t o, input int due);
        exp_t   e;
        longint acc;
        acc = longint'($signed(o.b));
        for (int k = 0; k < 4; k++)
            acc += (longint'($signed(o.d[k])) * longint'($signed(o.w[k]))) >>> 16;
        if (acc > 64'sd2147483647) begin
            e.res = SAT_MAX;
            e.ovf = 1'b1;
        end else if (acc < -64'sd2147483648) begin
            e.res = SAT_MIN;
            e.ovf = 1'b1;
        end else begin
            e.res = acc[31:0];
            e.ovf = 1'b0;
        end
        if (o.relu && e.res[31]) e.res = '0;
        e.due = due;
        return e;
    endfunction

    function automatic op_t mk(input logic [31:0] d, input logic [31:0] w,
                               input logic [31:0] b, input logic relu);
        op_t o;
        for (int k = 0; k < 4; k++) begin
            o.d[k] = d;
            o.w[k] = w;
        end
        o.b    = b;
        o.relu = relu;
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] v;
        if ($urandom_range(0, 3) == 0) begin
            v = $urandom;
        end else begin
            v = 32'($urandom_range(0, 32'h0003_FFFF));
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        for (int k = 0; k < 4; k++) begin
            o.d[k] = rand_word();
            o.w[k] = rand_word();
        end
        o.b    = rand_word();
        o.relu = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // Drive one cycle of stimulus; the model decides whether the request is taken.
    task automatic apply(input bit s, input op_t o);
        @(negedge clk);
        data0 = o.d[0]; data1 = o.d[1]; data2 = o.d[2]; data3 = o.d[3];
        weight0 = o.w[0]; weight1 = o.w[1]; weight2 = o.w[2]; weight3 = o.w[3];
        bias = o.b;
        relu_en = o.relu;
        start = s;
        last_op = o;
        if (s && cyc >= next_free) begin
            sb.push_back(model(o, cyc + 6));
            busy_lo   = cyc + 1;
            busy_hi   = cyc + 5;
            next_free = cyc + 6;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, last_op);
    endtask

    task automatic run_one(input op_t o);
        apply(1'b1, o);
        idle(6);
    endtask

    // Monitor: done timing, held result/overflow and busy window every cycle.
    always @(negedge clk) begin
        logic exp_done;
        exp_t e;
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        check("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            e = sb.pop_front();
            held_res = e.res;
            held_ovf = e.ovf;
        end
        check("result", result, held_res);
        check("overflow", 32'(overflow), 32'(held_ovf));
        check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        op_t a, z;
        last_op = mk('0, '0, '0, 1'b0);
        z = mk('0, '0, '0, 1'b0);

        // Reset state, checked directly and by the monitor.
        idle(2);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", result, 32'd0);
        #1 rst_n = 1'b1;
        idle(2);

        run_one(mk(32'h0001_0000, 32'h0000_8000, 32'h0, 1'b0));
        run_one(mk(32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 1'b0));
        run_one(mk(32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 1'b1));
        run_one(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0));
        run_one(mk(32'h8000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0));

        // Operand changes and a second start during the run must be ignored.
        a = mk(32'h0002_0000, 32'h0000_C000, 32'hFFFF_0000, 1'b0);
        apply(1'b1, a);
        apply(1'b0, z);
        apply(1'b1, z);
        idle(8);

        // Reset between E2 and E3 aborts the evaluation.
        apply(1'b1, a);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        sb.delete();
        held_res  = '0;
        held_ovf  = 1'b0;
        busy_lo   = 1;
        busy_hi   = 0;
        next_free = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(10);
        run_one(a);

        // Start held high: a new evaluation every 6 cycles.
        for (int i = 0; i < 24; i++) apply(1'b1, mk(32'h0000_4000, 32'hFFFE_8000, 32'h0000_1234, 1'b0));
        idle(8);

        // Random traffic, including extra starts that may land while busy.
        for (int n = 0; n < 60; n++) begin
            apply(1'b1, rand_op());
            repeat ($urandom_range(0, 7)) apply($urandom_range(0, 3) == 0, rand_op());
        end
        idle(10);
        check("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
